// File: rtl/count_tx_pkg.sv
// Shared types and constants for the count-to-UART decimal reporter.
package count_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    ISSUE,
    WAIT_DONE
  } state_t;

  localparam logic [7:0]  ASCII_ZERO  = 8'h30;
  localparam logic [7:0]  ASCII_SPACE = 8'h20;
  localparam logic [7:0]  ASCII_CR    = 8'h0D;
  localparam logic [7:0]  ASCII_LF    = 8'h0A;
  localparam logic [13:0] BCD_MAX     = 14'd9999;
  localparam int          CONV_CYCLES = 14;

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 (double-dabble) converter, one bit per clock.
// bcd[3] is thousands, bcd[0] is units.
module bin2bcd_seq
  import count_tx_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [13:0]     bin,
  output logic            done,
  output logic [3:0][3:0] bcd
);

  logic [13:0] shift_q;
  logic [15:0] bcd_q;
  logic [15:0] adj;
  logic [3:0]  iter_q;
  logic        run_q;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // High during the final iteration, so the caller can move on at the same
  // edge that makes bcd final.
  assign done = run_q && (iter_q == 4'(CONV_CYCLES - 1));
  assign bcd  = bcd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      run_q   <= 1'b0;
    end else if (start) begin
      shift_q <= bin;
      bcd_q   <= '0;
      iter_q  <= '0;
      run_q   <= 1'b1;
    end else if (run_q) begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      {bcd_q, shift_q} <= {adj, shift_q} << 1;
      iter_q           <= iter_q + 4'd1;
      if (done) run_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/count_tx_reporter.sv
// Snapshots the 14-bit count on a trigger and sends it as four ASCII decimal
// digits (plus optional CR/LF) over the UART TX start/done handshake.
module count_tx_reporter
  import count_tx_pkg::*;
#(
  parameter int SEND_CRLF    = 1,
  parameter int LEADING_ZERO = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [13:0] count,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy
);

  localparam logic [2:0] LAST_IDX = (SEND_CRLF != 0) ? 3'd5 : 3'd3;
  localparam logic       BLANK_EN = (LEADING_ZERO == 0);

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [7:0]      cur_byte;
  logic [13:0]     sat_count;
  logic            conv_start, conv_done;
  logic [3:0][3:0] digits;
  logic            blank3, blank2, blank1;

  assign sat_count  = (count > BCD_MAX) ? BCD_MAX : count;
  assign conv_start = (state_q == IDLE) && trigger;

  // The converter's digit register is the frozen snapshot of the report.
  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (sat_count),
    .done  (conv_done),
    .bcd   (digits)
  );

  assign blank3 = BLANK_EN && (digits[3] == 4'd0);
  assign blank2 = blank3 && (digits[2] == 4'd0);
  assign blank1 = blank2 && (digits[1] == 4'd0);

  always_comb begin
    case (idx_q)
      3'd0:    cur_byte = blank3 ? ASCII_SPACE : (ASCII_ZERO | {4'h0, digits[3]});
      3'd1:    cur_byte = blank2 ? ASCII_SPACE : (ASCII_ZERO | {4'h0, digits[2]});
      3'd2:    cur_byte = blank1 ? ASCII_SPACE : (ASCII_ZERO | {4'h0, digits[1]});
      3'd3:    cur_byte = ASCII_ZERO | {4'h0, digits[0]};
      3'd4:    cur_byte = ASCII_CR;
      default: cur_byte = ASCII_LF;
    endcase
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          idx_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (conv_done) state_d = ISSUE;
      end
      ISSUE: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = cur_byte;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != IDLE);

endmodule
